// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_pkg
//  Description : Shared definitions for the elevator call dispatcher: default
//                floor index width, SCAN direction codes and the dispatcher
//                FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package elevator_pkg;

    // Default floor index width (16 floors)
    localparam int FLOOR_W_DEFAULT = 4;

    // SCAN direction codes
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Dispatcher FSM states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SELECT   = 3'd1,
        ST_DISPATCH = 3'd2,
        ST_HOLD     = 3'd3,
        ST_DWELL    = 3'd4
    } state_t;

endpackage : elevator_pkg
`default_nettype wire

// File: rtl/elevator_scan_select.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_scan_select
//  Description : Combinational SCAN target finder. Given the pending call set,
//                the current floor and the preferred direction, returns the
//                next floor to serve:
//                  - the current floor if it has a pending call,
//                  - else the nearest pending floor in the preferred direction,
//                  - else the nearest pending floor in the opposite direction
//                    (and the flipped direction).
//  Ports       : pending   in  NUM_FLOORS  latched calls
//                cur_floor in  FLOOR_W     current floor (already in range)
//                dir       in  1           preferred direction (1=up)
//                hit       out 1           any call pending
//                target    out FLOOR_W     selected floor (valid when hit)
//                new_dir   out 1           direction after selection
//  Revision    : 1.0 - initial release
// ============================================================================
module elevator_scan_select
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 16,
    parameter int FLOOR_W    = FLOOR_W_DEFAULT
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  dir,
    output logic                  hit,
    output logic [FLOOR_W-1:0]    target,
    output logic                  new_dir
);

    logic               w_at_cur;
    logic               w_above_hit;
    logic               w_below_hit;
    logic [FLOOR_W-1:0] w_above;
    logic [FLOOR_W-1:0] w_below;

    // Ascending sweep: the first floor seen above the car is the nearest one
    // above; the last floor seen below the car is the nearest one below.
    always_comb begin
        w_at_cur    = 1'b0;
        w_above_hit = 1'b0;
        w_below_hit = 1'b0;
        w_above     = '0;
        w_below     = '0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (pending[f]) begin
                if (FLOOR_W'(f) == cur_floor) begin
                    w_at_cur = 1'b1;
                end else if (FLOOR_W'(f) > cur_floor) begin
                    if (!w_above_hit) begin
                        w_above_hit = 1'b1;
                        w_above     = FLOOR_W'(f);
                    end
                end else begin
                    w_below_hit = 1'b1;
                    w_below     = FLOOR_W'(f);
                end
            end
        end
    end

    always_comb begin
        hit     = |pending;
        target  = cur_floor;
        new_dir = dir;
        if (!w_at_cur) begin
            if (dir == DIR_UP) begin
                if (w_above_hit) begin
                    target = w_above;
                end else if (w_below_hit) begin
                    target  = w_below;
                    new_dir = DIR_DN;
                end
            end else begin
                if (w_below_hit) begin
                    target = w_below;
                end else if (w_above_hit) begin
                    target  = w_above;
                    new_dir = DIR_UP;
                end
            end
        end
    end

endmodule : elevator_scan_select
`default_nettype wire

// File: rtl/elevator_call_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_call_dispatcher
//  Description : Initiator side of the floor-request interface. Latches
//                hall/car calls, picks the next target with SCAN ordering,
//                drives Request_Floor to the elevator controller, clears each
//                call when its floor is served and holds the door open for a
//                dwell period.
//  Ports       : clk           in   1           rising-edge clock
//                reset         in   1           synchronous, active-high
//                Call_Req      in   NUM_FLOORS  per-floor call pulses
//                Cur_Floor     in   FLOOR_W     controller's current floor
//                Complete      in   1           controller arrival flag
//                Weight_Alert  in   1           overweight alert
//                Door_Alert    in   1           door-open-too-long alert
//                Request_Floor out  FLOOR_W     registered target floor
//                Req_Valid     out  1           target outstanding
//                Door_Cmd      out  1           door open (dwell)
//                Dir_Pref      out  1           SCAN direction, 1=up
//                Pending       out  NUM_FLOORS  latched unserved calls
//                Idle          out  1           idle with nothing pending
//  Revision    : 1.0 - initial release
// ============================================================================
module elevator_call_dispatcher
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS   = 16,
    parameter int FLOOR_W      = FLOOR_W_DEFAULT,
    parameter int DWELL_CYCLES = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] Call_Req,
    input  logic [FLOOR_W-1:0]    Cur_Floor,
    input  logic                  Complete,
    input  logic                  Weight_Alert,
    input  logic                  Door_Alert,
    output logic [FLOOR_W-1:0]    Request_Floor,
    output logic                  Req_Valid,
    output logic                  Door_Cmd,
    output logic                  Dir_Pref,
    output logic [NUM_FLOORS-1:0] Pending,
    output logic                  Idle
);

    localparam int                 c_cnt_w      = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_dwell_init = c_cnt_w'(DWELL_CYCLES - 1);
    localparam logic [FLOOR_W:0]   c_last_floor = (FLOOR_W + 1)'(NUM_FLOORS - 1);

    state_t                  r_state;
    logic [NUM_FLOORS-1:0]   r_pending;
    logic [FLOOR_W-1:0]      r_req_floor;
    logic                    r_req_valid;
    logic                    r_door_cmd;
    logic                    r_dir;
    logic [c_cnt_w-1:0]      r_dwell_cnt;

    logic [FLOOR_W-1:0]      w_cur_sel;
    logic                    w_scan_hit;
    logic [FLOOR_W-1:0]      w_scan_target;
    logic                    w_scan_dir;
    logic [NUM_FLOORS-1:0]   w_req_onehot;
    logic                    w_accept;
    logic                    w_dwell_call;
    logic [NUM_FLOORS-1:0]   w_set;
    logic [NUM_FLOORS-1:0]   w_clr;
    logic [NUM_FLOORS-1:0]   w_pending_next;
    logic                    w_rt_hit;
    logic [FLOOR_W-1:0]      w_rt_floor;

    // An out-of-range floor report is treated as the top floor for selection
    assign w_cur_sel = ({1'b0, Cur_Floor} > c_last_floor) ? c_last_floor[FLOOR_W-1:0] : Cur_Floor;

    elevator_scan_select #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_scan (
        .pending   (r_pending),
        .cur_floor (w_cur_sel),
        .dir       (r_dir),
        .hit       (w_scan_hit),
        .target    (w_scan_target),
        .new_dir   (w_scan_dir)
    );

    always_comb begin
        w_req_onehot = '0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            w_req_onehot[f] = (FLOOR_W'(f) == r_req_floor);
        end
    end

    // Arrival is judged against the raw controller floor, not the clamped one
    assign w_accept     = (r_state == ST_DISPATCH) && Complete && !Weight_Alert
                          && (Cur_Floor == r_req_floor);

    // While the door is open, a call for the dwell floor re-opens the door
    // instead of becoming a new pending call.
    assign w_dwell_call = (r_state == ST_DWELL) && |(Call_Req & w_req_onehot);
    assign w_set        = (r_state == ST_DWELL) ? (Call_Req & ~w_req_onehot) : Call_Req;
    assign w_clr        = w_accept ? w_req_onehot : '0;

    // Set is applied after clear so a simultaneous call survives the clear
    assign w_pending_next = (r_pending & ~w_clr) | w_set;

    // Nearest pending floor strictly between the car and the current target,
    // in the direction of travel.
    always_comb begin
        w_rt_hit   = 1'b0;
        w_rt_floor = r_req_floor;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (r_pending[f]) begin
                if (r_dir == DIR_UP) begin
                    if (!w_rt_hit && (FLOOR_W'(f) > w_cur_sel) && (FLOOR_W'(f) < r_req_floor)) begin
                        w_rt_hit   = 1'b1;
                        w_rt_floor = FLOOR_W'(f);
                    end
                end else begin
                    if ((FLOOR_W'(f) < w_cur_sel) && (FLOOR_W'(f) > r_req_floor)) begin
                        w_rt_hit   = 1'b1;
                        w_rt_floor = FLOOR_W'(f);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_pending   <= '0;
            r_req_floor <= Cur_Floor;
            r_req_valid <= 1'b0;
            r_door_cmd  <= 1'b0;
            r_dir       <= DIR_UP;
            r_dwell_cnt <= '0;
        end else begin
            r_pending <= w_pending_next;
            case (r_state)
                ST_IDLE: begin
                    // Keep the controller parked where it is
                    r_req_floor <= Cur_Floor;
                    if (|r_pending) begin
                        r_state <= ST_SELECT;
                    end
                end

                ST_SELECT: begin
                    if (w_scan_hit) begin
                        r_req_floor <= w_scan_target;
                        r_dir       <= w_scan_dir;
                        r_req_valid <= 1'b1;
                        r_state     <= ST_DISPATCH;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_DISPATCH: begin
                    if (w_accept) begin
                        r_req_valid <= 1'b0;
                        r_door_cmd  <= 1'b1;
                        r_dwell_cnt <= c_dwell_init;
                        r_state     <= ST_DWELL;
                    end else if (Weight_Alert || Door_Alert) begin
                        r_state <= ST_HOLD;
                    end else if (w_rt_hit) begin
                        r_req_floor <= w_rt_floor;
                    end
                end

                ST_HOLD: begin
                    if (!Weight_Alert && !Door_Alert) begin
                        r_state <= ST_DISPATCH;
                    end
                end

                ST_DWELL: begin
                    if (w_dwell_call) begin
                        r_dwell_cnt <= c_dwell_init;
                    end else if (!Weight_Alert) begin
                        // Overweight keeps the door open: counter and exit both frozen
                        if (r_dwell_cnt == '0) begin
                            r_door_cmd <= 1'b0;
                            r_state    <= (|r_pending) ? ST_SELECT : ST_IDLE;
                        end else begin
                            r_dwell_cnt <= r_dwell_cnt - c_cnt_w'(1);
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Request_Floor = r_req_floor;
    assign Req_Valid     = r_req_valid;
    assign Door_Cmd      = r_door_cmd;
    assign Dir_Pref      = r_dir;
    assign Pending       = r_pending;
    assign Idle          = (r_state == ST_IDLE) && (r_pending == '0);

endmodule : elevator_call_dispatcher
`default_nettype wire
